// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU main control FSM
module multicycle_control #(
    parameter int WAIT_MEM = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_e state_q;
    state_e state_d;
    logic   ready;

    // With WAIT_MEM=0 every memory access is assumed to finish in one cycle.
    assign ready = (WAIT_MEM == 0) ? 1'b1 : mem_ready;
    assign state = state_q;

    // State register; reset wins over any held memory state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control outputs; everything is forced low while reset is high.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default: begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (ready) state_d = S_FETCH;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_source     = 2'b01;
                    pc_write_cond = 1'b1;
                    state_d       = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    multicycle_control #(.WAIT_MEM(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // word packing: {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Expected control word for a state, written straight from the per-state rules.
    function automatic logic [16:0] ctl(input int st, input logic rdy, input logic ill);
        logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, op = 0, ps = 0;
        logic il = 0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; op = 2'b01; ps = 2'b01; pwc = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; end
            11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, il};
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic step(input logic rst_v, input logic rdy, input int st, input logic [16:0] w);
        exp_t e;
        reset     = rst_v;
        mem_ready = rdy;
        e.st      = st[3:0];
        e.w       = w;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One whole instruction from FETCH entry, with fw fetch waits and mw data-access waits.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        logic legal;
        opcode = op;
        legal  = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) ||
                 (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
        for (int i = 0; i < fw; i++) step(0, 0, 0, ctl(0, 0, 0));
        step(0, 1, 0, ctl(0, 1, 0));
        step(0, rnd(), 1, ctl(1, 0, !legal));
        case (op)
            6'h23: begin
                step(0, rnd(), 2, ctl(2, 0, 0));
                for (int i = 0; i < mw; i++) step(0, 0, 3, ctl(3, 0, 0));
                step(0, 1, 3, ctl(3, 0, 0));
                step(0, rnd(), 4, ctl(4, 0, 0));
            end
            6'h2B: begin
                step(0, rnd(), 2, ctl(2, 0, 0));
                for (int i = 0; i < mw; i++) step(0, 0, 5, ctl(5, 0, 0));
                step(0, 1, 5, ctl(5, 0, 0));
            end
            6'h00: begin
                step(0, rnd(), 6, ctl(6, 0, 0));
                step(0, rnd(), 7, ctl(7, 0, 0));
            end
            6'h04: step(0, rnd(), 8, ctl(8, 0, 0));
            6'h08: begin
                step(0, rnd(), 9, ctl(9, 0, 0));
                step(0, rnd(), 10, ctl(10, 0, 0));
            end
            6'h02: step(0, rnd(), 11, ctl(11, 0, 0));
            default: ;
        endcase
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [7];
        logic [5:0] r;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
        r = ops[$urandom_range(0, 6)];
        if (r == 6'h3F) begin
            r = 6'($urandom_range(0, 63));
            if (r == 6'h23 || r == 6'h2B || r == 6'h00 || r == 6'h04 || r == 6'h08 || r == 6'h02)
                r = 6'h3F;
        end
        return r;
    endfunction

    // Monitor: every queued cycle is compared mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic [16:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
            total++;
            if (state !== e.st) begin
                bad++;
                $display("FAIL state at %0t: got %0d expected %0d", $time, state, e.st);
            end
            total++;
            if (act !== e.w) begin
                bad++;
                $display("FAIL outputs at %0t (state %0d): got %b expected %b", $time, e.st, act, e.w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1, 1, 0, 17'd0);

        run_instr(6'h23, 0, 0);
        run_instr(6'h2B, 0, 3);
        run_instr(6'h00, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h08, 5, 0);

        // reset while sitting in MEMRD, with mem_ready high so it would otherwise advance
        opcode = 6'h23;
        step(0, 1, 0, ctl(0, 1, 0));
        step(0, 0, 1, ctl(1, 0, 0));
        step(0, 0, 2, ctl(2, 0, 0));
        step(0, 0, 3, ctl(3, 0, 0));
        step(1, 1, 3, 17'd0);
        run_instr(6'h00, 0, 0);

        // reset while MEMWR is held waiting
        opcode = 6'h2B;
        step(0, 1, 0, ctl(0, 1, 0));
        step(0, 1, 1, ctl(1, 0, 0));
        step(0, 1, 2, ctl(2, 0, 0));
        step(0, 0, 5, ctl(5, 0, 0));
        step(1, 0, 5, 17'd0);
        run_instr(6'h04, 1, 0);

        for (int n = 0; n < 60; n++)
            run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));

        reset     = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
